// File: rtl/reflet_uart_boot_loader_if.sv
// ----------------------------------------------------------------------------
// reflet_uart_boot_loader_if
// Bundle of the boot loader's system-facing signals.
//   boot_skip     host/board -> loader : release the CPU without loading
//   rx            host/board -> loader : UART receive line, idle high
//   mem_addr      loader -> RAM        : word address of the write
//   mem_data      loader -> RAM        : 16-bit word to write
//   mem_write_en  loader -> RAM        : one-cycle write strobe
//   inst_ready    loader -> controller : image stored and verified (or skipped)
//   load_error    loader -> controller : sticky, last load attempt failed
//   busy          loader -> controller : a load is in progress
// The loader itself connects through the slave modport; the surrounding
// system (or a testbench) drives through the master modport.
// ----------------------------------------------------------------------------
interface reflet_uart_boot_loader_if #(
  parameter int addr_size = 14
);
  logic                 boot_skip;
  logic                 rx;
  logic [addr_size-1:0] mem_addr;
  logic [15:0]          mem_data;
  logic                 mem_write_en;
  logic                 inst_ready;
  logic                 load_error;
  logic                 busy;

  modport master (
    output boot_skip, rx,
    input  mem_addr, mem_data, mem_write_en, inst_ready, load_error, busy
  );

  modport slave (
    input  boot_skip, rx,
    output mem_addr, mem_data, mem_write_en, inst_ready, load_error, busy
  );
endinterface

// File: rtl/reflet_uart_boot_loader.sv
// ----------------------------------------------------------------------------
// reflet_uart_boot_loader
// Receives a program image over an 8N1 UART and writes it word by word into
// the 16-bit instruction RAM, then raises inst_ready once the trailing
// checksum matches. boot_skip releases the CPU with the RAM untouched.
//
// Frame (little-endian): A5 | LEN_LO | LEN_HI | LEN x (lo, hi) | CSUM
// CSUM is the 8-bit wrapping sum of every byte between sync and CSUM.
//
// Ports
//   clk    system clock
//   reset  synchronous reset, active low
//   bus    reflet_uart_boot_loader_if.slave (see interface header)
// ----------------------------------------------------------------------------
module reflet_uart_boot_loader #(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600,
  parameter int inst_size = 128,
  parameter int addr_size = 14
) (
  input  logic                        clk,
  input  logic                        reset,
  reflet_uart_boot_loader_if.slave    bus
);

  // --------------------------------------------------------------------------
  // UART receiver
  // --------------------------------------------------------------------------
  localparam int bit_cycles  = clk_freq / baud_rate;
  localparam int half_cycles = bit_cycles / 2;
  localparam int cnt_w       = (bit_cycles > 2) ? $clog2(bit_cycles) : 1;
  localparam logic [cnt_w-1:0] bit_last  = cnt_w'(bit_cycles - 1);
  localparam logic [cnt_w-1:0] half_last = cnt_w'(half_cycles - 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  rx_state_t        rx_state, rx_state_next;
  logic             rx_meta, rx_sync, rx_prev;
  logic [cnt_w-1:0] rx_cnt, rx_cnt_next;
  logic [2:0]       rx_bit_idx, rx_bit_next;
  logic [7:0]       rx_shift, rx_shift_next;
  logic             byte_valid, byte_valid_next;
  logic             frame_err, frame_err_next;
  logic [7:0]       rx_data;

  // Synchroniser flops reset to the idle-high level so leaving reset never
  // looks like a falling edge.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // its pre-edge inputs; blocking here would collapse the synchroniser chain.
    if (!reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit_idx <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= bus.rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      rx_state   <= rx_state_next;
      rx_cnt     <= rx_cnt_next;
      rx_bit_idx <= rx_bit_next;
      rx_shift   <= rx_shift_next;
      byte_valid <= byte_valid_next;
      frame_err  <= frame_err_next;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    rx_state_next   = rx_state;
    rx_cnt_next     = rx_cnt + cnt_w'(1);
    rx_bit_next     = rx_bit_idx;
    rx_shift_next   = rx_shift;
    byte_valid_next = 1'b0;
    frame_err_next  = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        rx_cnt_next = '0;
        if (rx_prev && !rx_sync) rx_state_next = RX_START;
      end
      RX_START: begin
        // Mid-start re-check: a line back high means the edge was a glitch.
        if (rx_cnt == half_last) begin
          rx_cnt_next   = '0;
          rx_bit_next   = '0;
          rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        // Counting a full bit from the start-bit centre lands on data centres.
        if (rx_cnt == bit_last) begin
          rx_cnt_next   = '0;
          rx_shift_next = {rx_sync, rx_shift[7:1]};
          rx_bit_next   = rx_bit_idx + 3'd1;
          if (rx_bit_idx == 3'd7) rx_state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == bit_last) begin
          rx_cnt_next   = '0;
          rx_state_next = RX_IDLE;
          if (rx_sync) byte_valid_next = 1'b1;
          else         frame_err_next  = 1'b1;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  assign rx_data = rx_shift;

  // --------------------------------------------------------------------------
  // Load sequencer
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA_LO,
    S_DATA_HI,
    S_CSUM,
    S_DONE,
    S_ERROR
  } ld_state_t;

  ld_state_t            state, state_next;
  logic [7:0]           len_lo;
  logic [15:0]          len;
  logic [7:0]           data_lo;
  logic [7:0]           sum;
  logic [addr_size-1:0] word_cnt;
  logic [addr_size-1:0] mem_addr_q;
  logic [15:0]          mem_data_q;
  logic                 mem_write_en_q;
  logic                 load_error_q;
  logic [15:0]          len_rx;
  logic                 last_word;
  logic                 loading;

  assign len_rx    = {rx_data, len_lo};
  assign last_word = (32'(word_cnt) + 32'd1) == 32'(len);
  assign loading   = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                     (state == S_DATA_LO) || (state == S_DATA_HI) ||
                     (state == S_CSUM);

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (bus.boot_skip)                        state_next = S_DONE;
        else if (frame_err)                       state_next = S_ERROR;
        else if (byte_valid && rx_data == 8'hA5)  state_next = S_LEN_LO;
      end
      S_LEN_LO:  if (byte_valid) state_next = S_LEN_HI;
      S_LEN_HI: begin
        if (byte_valid) begin
          if (len_rx > 16'(inst_size)) state_next = S_ERROR;
          else if (len_rx == 16'd0)    state_next = S_CSUM;
          else                         state_next = S_DATA_LO;
        end
      end
      S_DATA_LO: if (byte_valid) state_next = S_DATA_HI;
      S_DATA_HI: if (byte_valid) state_next = last_word ? S_CSUM : S_DATA_LO;
      S_CSUM:    if (byte_valid) state_next = (rx_data == sum) ? S_DONE : S_ERROR;
      S_DONE:    state_next = S_DONE;
      S_ERROR:   state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
    // A broken frame anywhere inside a load abandons it.
    if (frame_err && loading) state_next = S_ERROR;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      len_lo         <= '0;
      len            <= '0;
      data_lo        <= '0;
      sum            <= '0;
      word_cnt       <= '0;
      mem_addr_q     <= '0;
      mem_data_q     <= '0;
      mem_write_en_q <= 1'b0;
      load_error_q   <= 1'b0;
    end else begin
      mem_write_en_q <= 1'b0;
      if (state == S_IDLE && state_next == S_LEN_LO) begin
        sum      <= '0;
        word_cnt <= '0;
      end
      if (byte_valid) begin
        unique case (state)
          S_LEN_LO: begin
            len_lo <= rx_data;
            sum    <= sum + rx_data;
          end
          S_LEN_HI: begin
            len <= len_rx;
            sum <= sum + rx_data;
          end
          S_DATA_LO: begin
            data_lo <= rx_data;
            sum     <= sum + rx_data;
          end
          S_DATA_HI: begin
            sum            <= sum + rx_data;
            mem_data_q     <= {rx_data, data_lo};
            mem_addr_q     <= word_cnt;
            mem_write_en_q <= 1'b1;
            word_cnt       <= word_cnt + addr_size'(1);
          end
          default: ;
        endcase
      end
      if (state_next == S_ERROR)     load_error_q <= 1'b1;
      else if (state_next == S_DONE) load_error_q <= 1'b0;
    end
  end

  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_data     = mem_data_q;
  assign bus.mem_write_en = mem_write_en_q;
  assign bus.load_error   = load_error_q;
  assign bus.inst_ready   = (state == S_DONE);
  assign bus.busy         = loading;

endmodule

// File: tb/tb_reflet_uart_boot_loader.sv
// ----------------------------------------------------------------------------
// tb_reflet_uart_boot_loader
// Directed and randomized image loads through the UART line. Expected RAM
// writes and final status are derived from the frame contents (word list,
// checksum rule, capacity limit), never from the DUT.
// ----------------------------------------------------------------------------
module tb_reflet_uart_boot_loader;
  localparam int clk_freq   = 1000000;
  localparam int baud_rate  = 62500;
  localparam int inst_size  = 128;
  localparam int addr_size  = 14;
  localparam int bit_cycles = clk_freq / baud_rate;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  reflet_uart_boot_loader_if #(.addr_size(addr_size)) bus ();

  reflet_uart_boot_loader #(
    .clk_freq (clk_freq),
    .baud_rate(baud_rate),
    .inst_size(inst_size),
    .addr_size(addr_size)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [addr_size-1:0] addr;
    logic [15:0]          data;
  } wr_t;

  wr_t got_q[$];

  always @(negedge clk)
    if (bus.mem_write_en === 1'b1) got_q.push_back('{bus.mem_addr, bus.mem_data});

  initial begin
    #900000;
    $display("FAIL watchdog: observed no end of run, expected finish before 90000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"},  32'(bus.mem_addr), 32'd0);
    check({tag, "_data"},  32'(bus.mem_data), 32'd0);
    check({tag, "_we"},    32'(bus.mem_write_en), 32'd0);
    check({tag, "_ready"}, 32'(bus.inst_ready), 32'd0);
    check({tag, "_err"},   32'(bus.load_error), 32'd0);
    check({tag, "_busy"},  32'(bus.busy), 32'd0);
  endtask

  // Holds reset for n cycles, checks the cleared outputs, then releases.
  task automatic do_reset(input string tag, input int n);
    @(negedge clk);
    reset = 1'b0;
    repeat (n) @(negedge clk);
    check_all_zero(tag);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // One 8N1 character; stop_level=0 forces a framing error.
  task automatic send_byte(input logic [7:0] b, input logic stop_level);
    bus.rx = 1'b0;
    repeat (bit_cycles) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (bit_cycles) @(negedge clk);
    end
    bus.rx = stop_level;
    repeat (bit_cycles) @(negedge clk);
    bus.rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Reference frame builder: sync, length, words lo/hi, wrapping byte sum.
  task automatic make_frame(input logic [15:0] words[$], input bit bad_csum,
                            output logic [7:0] f[$]);
    logic [7:0]  s;
    logic [15:0] n;
    n = 16'(words.size());
    f = {};
    f.push_back(8'hA5);
    f.push_back(n[7:0]);
    f.push_back(n[15:8]);
    foreach (words[i]) begin
      f.push_back(words[i][7:0]);
      f.push_back(words[i][15:8]);
    end
    s = 8'd0;
    for (int i = 1; i < f.size(); i++) s = s + f[i];
    f.push_back(bad_csum ? s + 8'd1 : s);
  endtask

  // Every word of a length-accepted frame lands at consecutive addresses from 0.
  task automatic check_writes(input string tag, input logic [15:0] words[$]);
    check({tag, "_nwr"}, 32'(got_q.size()), 32'(words.size()));
    for (int i = 0; i < words.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(got_q[i].addr), 32'(i));
      check($sformatf("%s_data%0d", tag, i), 32'(got_q[i].data), 32'(words[i]));
    end
    got_q.delete();
  endtask

  task automatic load_and_check(input string tag, input logic [15:0] words[$], input bit bad);
    logic [7:0] f[$];
    make_frame(words, bad, f);
    foreach (f[i]) send_byte(f[i], 1'b1);
    repeat (4) @(negedge clk);
    check_writes(tag, words);
    check({tag, "_ready"}, 32'(bus.inst_ready), bad ? 32'd0 : 32'd1);
    check({tag, "_err"},   32'(bus.load_error), bad ? 32'd1 : 32'd0);
    check({tag, "_busy"},  32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [15:0] w[$];
    logic [7:0]  g;
    bit          ok;
    bit          bad;
    int          n;

    bus.rx        = 1'b1;
    bus.boot_skip = 1'b1;

    // Skip path: ready within two cycles of reset release, no writes.
    do_reset("rst_skip", 3);
    ok = 1'b0;
    for (int i = 0; i < 2 && !ok; i++) begin
      if (bus.inst_ready === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    check("skip_ready", 32'(ok), 32'd1);
    check("skip_err", 32'(bus.load_error), 32'd0);
    check("skip_nwr", 32'(got_q.size()), 32'd0);
    bus.boot_skip = 1'b0;

    // Two-word image, good checksum.
    do_reset("rst_t2", 2);
    w = '{16'h1234, 16'h5678};
    load_and_check("t2", w, 1'b0);

    // Corrupted checksum, then the corrected frame without a reset.
    do_reset("rst_t3", 2);
    load_and_check("t3_bad", w, 1'b1);
    load_and_check("t3_good", w, 1'b0);

    // Length one past capacity is refused before any data.
    do_reset("rst_t4", 2);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h81, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (4) @(negedge clk);
    check("t4_ovf_nwr", 32'(got_q.size()), 32'd0);
    check("t4_ovf_err", 32'(bus.load_error), 32'd1);
    check("t4_ovf_ready", 32'(bus.inst_ready), 32'd0);
    w = {};
    load_and_check("t4_empty", w, 1'b0);

    // Framing error mid-data, with garbage bytes before the sync.
    do_reset("rst_t5", 2);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    check("t5_idle_busy", 32'(bus.busy), 32'd0);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h34, 1'b1);
    check("t5_busy", 32'(bus.busy), 32'd1);
    send_byte(8'h12, 1'b0);
    repeat (4) @(negedge clk);
    check("t5_ferr_err", 32'(bus.load_error), 32'd1);
    check("t5_ferr_busy", 32'(bus.busy), 32'd0);
    check("t5_ferr_nwr", 32'(got_q.size()), 32'd0);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    w = '{16'h1234, 16'h5678};
    load_and_check("t5_retry", w, 1'b0);

    // Reset while waiting for the low byte of word 1.
    do_reset("rst_t6", 2);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    repeat (3) @(negedge clk);
    check("t6_busy", 32'(bus.busy), 32'd1);
    check("t6_data", 32'(bus.mem_data), 32'h1234);
    do_reset("t6_midreset", 1);
    got_q.delete();
    check("t6_ready_after", 32'(bus.inst_ready), 32'd0);
    load_and_check("t6_resend", w, 1'b0);

    // Random images, optional bad checksum, a stray non-sync byte first.
    for (int r = 0; r < 6; r++) begin
      do_reset($sformatf("rst_r%0d", r), 2);
      n   = int'($urandom_range(1, 6));
      bad = ($urandom_range(0, 3) == 0);
      w   = {};
      for (int i = 0; i < n; i++) w.push_back(16'($urandom));
      g = 8'($urandom);
      if (g == 8'hA5) g = 8'h5A;
      send_byte(g, 1'b1);
      load_and_check($sformatf("rnd%0d", r), w, bad);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
